cpu_io_bridge: RTL and testbench
================================

Name: cpu_io_bridge

Overview:
Sits directly downstream of the cpu memory port (mem_a, mem_dout, mem_wr, mem_din). It decodes each byte access and routes it to the 128KB RAM or to the memory-mapped I/O space at mem_a[17:16]==2'b11. It buffers UART output, hands off UART input, supplies the running cycle counter and latches the program-stop request. It drives the cpu's rdy_in to stall the core on I/O backpressure.

Parameters:
RAM_ADDR_WIDTH, 17, RAM byte address width (128KB).
TX_FIFO_LOG, 3, log2 of the tx FIFO depth (default depth 8).

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-low
cpu_a  input  32  byte address from cpu (only bits 17:0 decoded)
cpu_dout  input  8  write data from cpu
cpu_wr  input  1  1 = write, 0 = read
cpu_din  output  8  read data to cpu, valid the cycle after the read is accepted
cpu_rdy  output  1  to cpu rdy_in; 0 = freeze cpu, which holds address/data/wr stable
ram_a  output  RAM_ADDR_WIDTH  RAM address
ram_din  output  8  RAM write data
ram_wr  output  1  RAM write enable
ram_dout  input  8  RAM read data, one cycle after address
rx_data  input  8  UART receive byte
rx_valid  input  1  rx_data available
rx_pop  output  1  one-cycle pulse consuming rx_data
tx_data  output  8  FIFO head byte to UART
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  UART accepts tx_data this cycle
program_stop  output  1  sticky program-stop flag

Behaviour:
- Reset (rst_in==0 at posedge): tx FIFO emptied, cycle counter=0, snapshot=0, program_stop=0, io_rdata=0, sel_io=0. While rst_in==0: cpu_rdy=0, ram_wr=0, rx_pop=0, tx_valid=0, cpu_din=0.
- Decode: io = (cpu_a[17:16]==2'b11). ram_sel = (cpu_a[17]==0). Addresses 0x20000-0x2FFFF are a hole: writes dropped, reads return 0x00.
- RAM path:
  - ram_a = cpu_a[16:0] and ram_din = cpu_dout, combinational.
  - ram_wr = cpu_wr & ram_sel & cpu_rdy.
- Read return: an accepted read registers sel_io; next cycle cpu_din = sel_io ? io_rdata : ram_dout. Latency is exactly 1 cycle for every target.
- Cycle counter: 32-bit, +1 every cycle out of reset (including stalled cycles), wraps 0xFFFFFFFF->0.
- 0x30000 read:
  - If rx_valid=0: cpu_rdy=0.
  - If rx_valid=1: accept, rx_pop=1 for that cycle, io_rdata<=rx_data.
- 0x30000 write:
  - cpu_dout==0x00: ignored, no stall.
  - Otherwise: push cpu_dout into tx FIFO. If the FIFO is full, cpu_rdy=0 and there is no push.
- 0x30004-0x30007 read:
  - Byte k = cpu_a[1:0] returns snapshot[8k+7:8k].
  - A read of 0x30004 loads snapshot<=counter and io_rdata<=counter[7:0], giving a coherent 4-byte word.
- 0x30004 write (any data):
  - Pushes 0x00 into tx FIFO; stalls if full.
  - Sets program_stop=1 on the same edge as the push. Sticky until reset.
  - Later writes to 0x30000/0x30004 are still accepted.
- Other I/O addresses (0x30001-0x30003, 0x30008 and up): reads return 0x00, writes ignored, no stall.
- TX FIFO:
  - Depth 2^TX_FIFO_LOG; pointers are TX_FIFO_LOG+1 bits with wrap.
  - tx_valid = !empty; tx_data = head.
  - Pop when tx_valid & tx_ready.
- Full is evaluated on the current state. When full with a simultaneous pop, the pop occurs, the push is refused and cpu_rdy=0 that cycle; the push is accepted next cycle. No overflow, no byte loss. When empty, a push and tx_ready in the same cycle produce no pop that cycle.
- cpu_rdy is combinational and is 0 only in the stall cases above (or during reset).

Test Plan:
- Reset: hold rst_in=0 3 cycles with cpu_wr=1 at 0x30000 -> cpu_rdy=0, ram_wr=0, tx_valid=0, program_stop=0; first cycle out of reset the counter reads 0.
- RAM: write 0xA5 to 0x00123, then read 0x00123 -> ram_wr pulses 1 cycle with ram_a=0x00123; cpu_din=0xA5 the cycle after the read.
- TX backpressure: tx_ready=0, write 0x41 nine times -> 8 accepted, 9th holds cpu_rdy=0; raise tx_ready 1 cycle -> 0x41 pops, the 9th is accepted next cycle, cpu_rdy=1. Write 0x00 -> no push.
- RX: rx_valid=0, read 0x30000 -> cpu_rdy=0 for 4 cycles; assert rx_valid with rx_data=0x37 -> rx_pop pulses once, cpu_din=0x37 next cycle.
- Counter: at counter=0x000001FF read 0x30004..0x30007 on consecutive cycles -> bytes 0xFF,0x01,0x00,0x00 (snapshot, not live value); wrap from 0xFFFFFFFF to 0.
- Stop: write 0x30004 with tx FIFO full -> stall until space, then 0x00 enters FIFO and program_stop=1 on the same edge; remains 1 until rst_in=0.

Source files
------------

// File: rtl/cpu_io_bridge.sv
// CPU memory-port bridge: routes byte accesses to a 128KB RAM or to the I/O page at 0x3xxxx
// (UART tx FIFO / rx hand-off, cycle counter snapshot, program-stop flag) and stalls the core on I/O backpressure.
module cpu_io_bridge #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_LOG    = 3
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [31:0]               cpu_a,
  input  logic [7:0]                cpu_dout,
  input  logic                      cpu_wr,
  output logic [7:0]                cpu_din,
  output logic                      cpu_rdy,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a,
  output logic [7:0]                ram_din,
  output logic                      ram_wr,
  input  logic [7:0]                ram_dout,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_pop,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      program_stop
);

  localparam int DEPTH = 1 << TX_FIFO_LOG;

  logic                 io_sel, ram_sel;
  logic [15:0]          io_off;
  logic                 rx_rd, snap_rd, tx_wr, stop_wr, push_req;
  logic                 fifo_full, fifo_empty, stall;
  logic                 push, pop, rd_acc;
  logic [7:0]           push_byte;
  logic                 unused_hi_addr;

  logic [TX_FIFO_LOG:0] wr_ptr_q, wr_ptr_d;
  logic [TX_FIFO_LOG:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]           fifo_mem [DEPTH];
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          snap_q, snap_d;
  logic [7:0]           io_rdata_q, io_rdata_d;
  logic                 sel_io_q, sel_io_d;
  logic                 stop_q, stop_d;

  function automatic logic [7:0] snap_byte(input logic [31:0] word, input logic [1:0] k);
    return word[8*k +: 8];
  endfunction

  assign unused_hi_addr = ^cpu_a[31:18];

  // Address decode and handshake (combinational)
  always_comb begin
    io_sel    = (cpu_a[17:16] == 2'b11);
    ram_sel   = !cpu_a[17];
    io_off    = cpu_a[15:0];
    rx_rd     = io_sel && !cpu_wr && (io_off == 16'h0000);
    snap_rd   = io_sel && !cpu_wr && (io_off[15:2] == 14'd1);
    tx_wr     = io_sel && cpu_wr && (io_off == 16'h0000) && (cpu_dout != 8'h00);
    stop_wr   = io_sel && cpu_wr && (io_off == 16'h0004);
    push_req  = tx_wr || stop_wr;
    push_byte = stop_wr ? 8'h00 : cpu_dout;

    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[TX_FIFO_LOG] != rd_ptr_q[TX_FIFO_LOG]) &&
                 (wr_ptr_q[TX_FIFO_LOG-1:0] == rd_ptr_q[TX_FIFO_LOG-1:0]);

    stall   = (rx_rd && !rx_valid) || (push_req && fifo_full);
    cpu_rdy = rst_in && !stall;
    push    = push_req && cpu_rdy;
    rd_acc  = !cpu_wr && cpu_rdy;

    tx_valid = rst_in && !fifo_empty;
    tx_data  = fifo_mem[rd_ptr_q[TX_FIFO_LOG-1:0]];
    pop      = tx_valid && tx_ready;

    rx_pop  = rx_rd && cpu_rdy;
    ram_a   = cpu_a[RAM_ADDR_WIDTH-1:0];
    ram_din = cpu_dout;
    ram_wr  = cpu_wr && ram_sel && cpu_rdy;

    cpu_din      = !rst_in ? 8'h00 : (sel_io_q ? io_rdata_q : ram_dout);
    program_stop = stop_q;
  end

  // Next-state computation
  always_comb begin
    cnt_d      = cnt_q + 32'd1;
    wr_ptr_d   = wr_ptr_q + {{TX_FIFO_LOG{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{TX_FIFO_LOG{1'b0}}, pop};
    stop_d     = stop_q || (push && stop_wr);
    snap_d     = snap_q;
    io_rdata_d = io_rdata_q;
    sel_io_d   = sel_io_q;
    if (rd_acc) begin
      sel_io_d   = !ram_sel;
      io_rdata_d = 8'h00;
      if (rx_rd) begin
        io_rdata_d = rx_data;
      end else if (snap_rd) begin
        if (io_off[1:0] == 2'd0) begin
          snap_d     = cnt_q;
          io_rdata_d = cnt_q[7:0];
        end else begin
          io_rdata_d = snap_byte(snap_q, io_off[1:0]);
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      snap_q     <= '0;
      io_rdata_q <= '0;
      sel_io_q   <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      io_rdata_q <= io_rdata_d;
      sel_io_q   <= sel_io_d;
      stop_q     <= stop_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr_q[TX_FIFO_LOG-1:0]] <= push_byte;
    end
  end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Bench for cpu_io_bridge: directed scenarios plus randomized traffic, scored against a queue/array reference model.
module tb_cpu_io_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic [16:0] ram_a;
  logic [7:0]  ram_din;
  logic        ram_wr;
  logic [7:0]  ram_dout = 8'h00;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        program_stop;

  always #5 clk_in = ~clk_in;

  cpu_io_bridge dut (
    .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
    .cpu_din(cpu_din), .cpu_rdy(cpu_rdy), .ram_a(ram_a), .ram_din(ram_din), .ram_wr(ram_wr),
    .ram_dout(ram_dout), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .program_stop(program_stop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // external RAM: one-cycle registered read
  logic [7:0] ram_mem [0:131071] = '{default: 8'h00};
  always @(posedge clk_in) begin
    if (ram_wr) ram_mem[ram_a] <= ram_din;
    ram_dout <= ram_mem[ram_a];
  end

  // reference model state
  logic [31:0] model_cnt = 32'd0;
  always @(posedge clk_in) model_cnt <= rst_in ? model_cnt + 32'd1 : 32'd0;

  logic [7:0]  expq[$];
  logic [7:0]  txq[$];
  logic [7:0]  ref_ram [int];
  int          pushes = 0;
  int          pops = 0;
  bit          stop_m = 1'b0;
  logic [31:0] snap_m = 32'd0;
  bit          env_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // read-data monitor: one cycle after an accepted read
  bit         rd_pending = 1'b0;
  logic [7:0] mon_e;
  always @(negedge clk_in) begin
    if (rd_pending && rst_in) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cpu_din_unexpected: got %0h, expected no read outstanding", cpu_din);
      end else begin
        mon_e = expq.pop_front();
        chk("cpu_din", 32'(cpu_din), 32'(mon_e));
      end
    end
    rd_pending = rst_in && cpu_rdy && !cpu_wr;
  end

  // tx monitor: every byte handed to the UART must be the oldest accepted push
  always @(negedge clk_in) begin
    #2;
    if (rst_in && tx_valid && tx_ready) begin
      if (txq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got %0h, expected empty FIFO", tx_data);
      end else begin
        chk("tx_data", 32'(tx_data), 32'(txq.pop_front()));
      end
      pops++;
    end
  end

  // random UART environment
  always @(posedge clk_in) begin
    #1;
    if (env_rand) begin
      tx_ready = ($urandom_range(0, 1) == 1);
      rx_valid = ($urandom_range(0, 3) != 0);
      rx_data  = 8'($urandom);
    end
  end

  // hook_kind: 1 = pulse tx_ready for one cycle, 2 = present rx byte 0x37; fires after hook_at stalls
  task automatic access(input logic [31:0] a, input logic wr, input logic [7:0] d,
                        input int hook_at, input int hook_kind, output int stalls);
    logic [15:0] off;
    bit          io, hooked, exp_rdy, is_push;
    logic [7:0]  e;
    int          k;
    cpu_a = a; cpu_wr = wr; cpu_dout = d;
    stalls = 0; hooked = 1'b0;
    io = (a[17:16] == 2'b11);
    off = a[15:0];
    is_push = io && wr && ((off == 16'h0000 && d != 8'h00) || off == 16'h0004);
    forever begin
      @(negedge clk_in);
      chk("program_stop", 32'(program_stop), 32'(stop_m));
      if (io && !wr && off == 16'h0000) exp_rdy = rx_valid;
      else if (is_push)                exp_rdy = ((pushes - pops) < 8);
      else                             exp_rdy = 1'b1;
      chk("cpu_rdy", 32'(cpu_rdy), 32'(exp_rdy));
      if (cpu_rdy) break;
      stalls++;
      if (stalls > 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL access_timeout: addr %0h still stalled, expected acceptance", a);
        @(posedge clk_in); #1;
        return;
      end
      @(posedge clk_in); #1;
      if (hooked && hook_kind == 1) tx_ready = 1'b0;
      if (stalls == hook_at) begin
        hooked = 1'b1;
        if (hook_kind == 1) tx_ready = 1'b1;
        if (hook_kind == 2) begin rx_valid = 1'b1; rx_data = 8'h37; end
      end
    end
    chk("ram_wr", 32'(ram_wr), 32'(wr && !a[17]));
    chk("rx_pop", 32'(rx_pop), 32'(io && !wr && off == 16'h0000));
    k = int'(a[16:0]);
    if (wr && !a[17]) begin
      chk("ram_a", 32'(ram_a), 32'(a[16:0]));
      chk("ram_din", 32'(ram_din), 32'(d));
      ref_ram[k] = d;
    end
    if (is_push) begin
      txq.push_back(off == 16'h0004 ? 8'h00 : d);
      pushes++;
      if (off == 16'h0004) stop_m = 1'b1;
    end
    if (!wr) begin
      if (!a[17])                               e = ref_ram.exists(k) ? ref_ram[k] : 8'h00;
      else if (!io)                             e = 8'h00;
      else if (off == 16'h0000)                 e = rx_data;
      else if (off == 16'h0004) begin           snap_m = model_cnt; e = model_cnt[7:0]; end
      else if (off >= 16'h0005 && off <= 16'h0007) e = snap_m[8*off[1:0] +: 8];
      else                                      e = 8'h00;
      expq.push_back(e);
    end
    @(posedge clk_in); #1;
    if (hook_kind == 2 && !env_rand) rx_valid = 1'b0;
  endtask

  task automatic idle();
    int s;
    access(32'h0002_0000, 1'b0, 8'h00, 0, 0, s);
  endtask

  task automatic do_reset();
    env_rand = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    rst_in = 1'b0; cpu_a = 32'h0003_0000; cpu_wr = 1'b1; cpu_dout = 8'h55;
    @(posedge clk_in);
    repeat (3) begin
      @(negedge clk_in);
      chk("rst_cpu_rdy", 32'(cpu_rdy), 0);
      chk("rst_ram_wr", 32'(ram_wr), 0);
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_rx_pop", 32'(rx_pop), 0);
      chk("rst_cpu_din", 32'(cpu_din), 0);
      chk("rst_program_stop", 32'(program_stop), 0);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    txq.delete(); expq.delete();
    pushes = 0; pops = 0; stop_m = 1'b0; snap_m = 32'd0;
  endtask

  task automatic drain();
    int g = 0;
    tx_ready = 1'b1;
    while (txq.size() != 0 && g < 200) begin idle(); g++; end
    chk("tx_drain", 32'(txq.size()), 0);
    idle();
    chk("tx_valid_empty", 32'(tx_valid), 0);
  endtask

  task automatic rand_access();
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
    int          s;
    wr = ($urandom_range(0, 1) == 1);
    d  = 8'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2: a = 32'($urandom_range(0, 1)) * 32'h0001_FFF0 + 32'($urandom_range(0, 7));
      3:       a = 32'h0002_0000 + 32'($urandom_range(0, 16'hFFFF));
      4:       begin a = 32'h0003_0000; if ($urandom_range(0, 3) == 0) d = 8'h00; end
      5:       a = 32'h0003_0004 + 32'($urandom_range(0, 3));
      6:       begin a = 32'h0003_0004; wr = 1'b0; end
      7:       a = 32'h0003_0000 + 32'($urandom_range(1, 3));
      8:       a = 32'h0003_0008 + 32'($urandom_range(0, 16'hFFF7));
      default: begin a = 32'h0003_0000; wr = 1'b0; end
    endcase
    a[31:18] = 14'($urandom);
    access(a, wr, d, 0, 0, s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int g;
    rst_in = 1'b0; cpu_a = 32'd0; cpu_dout = 8'h00; cpu_wr = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    @(posedge clk_in); #1;
    do_reset();

    // first cycle out of reset: counter snapshot is 0
    access(32'h0003_0004, 1'b0, 8'h00, 0, 0, s);

    access(32'h0000_0123, 1'b1, 8'hA5, 0, 0, s);
    access(32'h0000_0123, 1'b0, 8'h00, 0, 0, s);

    // tx backpressure
    tx_ready = 1'b0;
    repeat (8) begin
      access(32'h0003_0000, 1'b1, 8'h41, 0, 0, s);
      chk("tx_fill_stalls", 32'(s), 0);
    end
    access(32'h0003_0000, 1'b1, 8'h41, 1, 1, s);
    chk("tx_full_stalls", 32'(s), 2);
    access(32'h0003_0000, 1'b1, 8'h00, 0, 0, s);
    chk("tx_zero_stalls", 32'(s), 0);
    drain();

    // rx hand-off
    rx_valid = 1'b0;
    access(32'h0003_0000, 1'b0, 8'h00, 4, 2, s);
    chk("rx_stalls", 32'(s), 4);
    idle();

    // program stop with full FIFO
    tx_ready = 1'b0;
    repeat (8) access(32'h0003_0000, 1'b1, 8'($urandom_range(1, 255)), 0, 0, s);
    access(32'h0003_0004, 1'b1, 8'h99, 1, 1, s);
    chk("stop_stalls", 32'(s), 2);
    tx_ready = 1'b1;
    access(32'h0003_0000, 1'b1, 8'h42, 0, 0, s);
    access(32'h0003_0004, 1'b1, 8'h07, 0, 0, s);
    drain();

    // counter snapshot at 0x1FF
    do_reset();
    g = 0;
    while (model_cnt != 32'h0000_01FF && g < 600) begin idle(); g++; end
    access(32'h0003_0004, 1'b0, 8'h00, 0, 0, s);
    access(32'h0003_0005, 1'b0, 8'h00, 0, 0, s);
    access(32'h0003_0006, 1'b0, 8'h00, 0, 0, s);
    access(32'h0003_0007, 1'b0, 8'h00, 0, 0, s);
    repeat (3) idle();
    access(32'h0003_0005, 1'b0, 8'h00, 0, 0, s);

    // randomized traffic
    env_rand = 1'b1;
    repeat (400) rand_access();
    env_rand = 1'b0;
    rx_valid = 1'b0;
    drain();

    do_reset();
    access(32'h0003_0004, 1'b0, 8'h00, 0, 0, s);
    idle();
    @(negedge clk_in); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
